mul_datapath: RTL and testbench

- 32-bit single-bus CPU datapath slice driven by externally sequenced control strobes (the control unit or bench supplies every `*in`/`*out`/op strobe each cycle).
- Holds PC, IR, MAR, MDR, Y, a 64-bit Z, HI, LO and general registers R1, R6, R7.
- Its ALU supports PC increment, add and signed 32x32->64 multiply.
- Sits between the control unit and memory; memory data enters only through `Mdatain` into MDR.

---
 rtl/mul_datapath.sv | 156 +++++++++++++++
 tb/tb_mul_datapath.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_datapath.sv
// rtl/mul_datapath.sv - single-bus CPU datapath slice with add/increment/signed-multiply ALU
// Registers load from one shared bus; all sequencing comes from external control strobes.

module booth_r4_mul #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] product
);

   localparam int PW  = 2 * WIDTH;
   localparam int NPP = WIDTH / 2;

   logic [PW-1:0] a_ext;
   logic [WIDTH:0] b_ext;
   logic [PW-1:0] pp [NPP];
   logic [2:0]    digit;

   assign a_ext = {{WIDTH{a[WIDTH-1]}}, a};
   assign b_ext = {b, 1'b0};

   // Each overlapping bit triplet of b selects one of {0, +-a, +-2a}, weighted by 4^i.
   always_comb begin
      digit = 3'b000;
      for (int i = 0; i < NPP; i++) begin
         digit = b_ext[2*i+2 -: 3];
         case (digit)
            3'b001, 3'b010: pp[i] = a_ext << (2 * i);
            3'b011:         pp[i] = (a_ext << 1) << (2 * i);
            3'b100:         pp[i] = (-(a_ext << 1)) << (2 * i);
            3'b101, 3'b110: pp[i] = (-a_ext) << (2 * i);
            default:        pp[i] = '0;
         endcase
      end
   end

   logic [PW-1:0] acc [NPP];

   // Pairwise reduction: log2(NPP) levels of two-input adders.
   always_comb begin
      for (int j = 0; j < NPP; j++) begin
         acc[j] = pp[j];
      end
      for (int s = 1; s < NPP; s = s * 2) begin
         for (int j = 0; j + s < NPP; j = j + 2 * s) begin
            acc[j] = acc[j] + acc[j+s];
         end
      end
      product = acc[0];
   end

endmodule

module mul_datapath #(
   parameter int WIDTH = 32
) (
   input  logic             Clock,
   input  logic             Resetn,
   input  logic             PCout,
   input  logic             Zlowout,
   input  logic             Zhighout,
   input  logic             MDRout,
   input  logic             R6out,
   input  logic             R7out,
   input  logic             LOin,
   input  logic             HIin,
   input  logic             MARin,
   input  logic             Zin,
   input  logic             PCin,
   input  logic             MDRin,
   input  logic             IRin,
   input  logic             Yin,
   input  logic             R1in,
   input  logic             R6in,
   input  logic             R7in,
   input  logic             IncPC,
   input  logic             Read,
   input  logic             MUL,
   input  logic [WIDTH-1:0] Mdatain,
   output logic [WIDTH-1:0] BusMuxOut,
   output logic [WIDTH-1:0] PC_q,
   output logic [WIDTH-1:0] IR_q,
   output logic [WIDTH-1:0] MAR_q,
   output logic [WIDTH-1:0] HI_q,
   output logic [WIDTH-1:0] LO_q
);

   logic [WIDTH-1:0]   pc, ir, mar, mdr, y, hi, lo, r1, r6, r7;
   logic [2*WIDTH-1:0] z;
   logic [WIDTH-1:0]   bus;
   logic [WIDTH-1:0]   mdr_d;
   logic [2*WIDTH-1:0] alu_c;
   logic [2*WIDTH-1:0] mul_c;

   // Priority only matters when control is not one-hot.
   always_comb begin
      bus = '0;
      if (Zhighout)    bus = z[2*WIDTH-1:WIDTH];
      else if (Zlowout) bus = z[WIDTH-1:0];
      else if (R7out)   bus = r7;
      else if (R6out)   bus = r6;
      else if (MDRout)  bus = mdr;
      else if (PCout)   bus = pc;
   end

   assign mdr_d = Read ? Mdatain : bus;

   booth_r4_mul #(.WIDTH(WIDTH)) u_mul (
      .a       (y),
      .b       (bus),
      .product (mul_c)
   );

   always_comb begin
      alu_c = {{WIDTH{1'b0}}, y + bus};
      if (MUL)        alu_c = mul_c;
      else if (IncPC) alu_c = {{WIDTH{1'b0}}, bus + 1'b1};
   end

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         pc  <= '0;
         ir  <= '0;
         mar <= '0;
         mdr <= '0;
         y   <= '0;
         z   <= '0;
         hi  <= '0;
         lo  <= '0;
         r1  <= '0;
         r6  <= '0;
         r7  <= '0;
      end else begin
         if (PCin)  pc  <= bus;
         if (IRin)  ir  <= bus;
         if (MARin) mar <= bus;
         if (MDRin) mdr <= mdr_d;
         if (Yin)   y   <= bus;
         if (Zin)   z   <= alu_c;
         if (HIin)  hi  <= bus;
         if (LOin)  lo  <= bus;
         if (R1in)  r1  <= bus;
         if (R6in)  r6  <= bus;
         if (R7in)  r7  <= bus;
      end
   end

   assign BusMuxOut = bus;
   assign PC_q      = pc;
   assign IR_q      = ir;
   assign MAR_q     = mar;
   assign HI_q      = hi;
   assign LO_q      = lo;

endmodule

// File: tb/tb_mul_datapath.sv
// tb/tb_mul_datapath.sv - directed checks of mul_datapath transfers, fetch, add/inc and signed multiply

module tb_mul_datapath;

   logic        Clock;
   logic        Resetn;
   logic        PCout, Zlowout, Zhighout, MDRout, R6out, R7out;
   logic        LOin, HIin, MARin, Zin, PCin, MDRin, IRin, Yin, R1in, R6in, R7in;
   logic        IncPC, Read, MUL;
   logic [31:0] Mdatain;
   logic [31:0] BusMuxOut, PC_q, IR_q, MAR_q, HI_q, LO_q;

   int total;
   int passed;

   mul_datapath dut (
      .Clock(Clock), .Resetn(Resetn),
      .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
      .R6out(R6out), .R7out(R7out),
      .LOin(LOin), .HIin(HIin), .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin),
      .IRin(IRin), .Yin(Yin), .R1in(R1in), .R6in(R6in), .R7in(R7in),
      .IncPC(IncPC), .Read(Read), .MUL(MUL), .Mdatain(Mdatain),
      .BusMuxOut(BusMuxOut), .PC_q(PC_q), .IR_q(IR_q), .MAR_q(MAR_q),
      .HI_q(HI_q), .LO_q(LO_q)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   typedef enum logic [1:0] {OP_ADD, OP_MUL, OP_INC} op_t;

   typedef struct {
      op_t         op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
   } vec_t;

   vec_t vecs [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic idle();
      PCout = 0; Zlowout = 0; Zhighout = 0; MDRout = 0; R6out = 0; R7out = 0;
      LOin = 0; HIin = 0; MARin = 0; Zin = 0; PCin = 0; MDRin = 0; IRin = 0;
      Yin = 0; R1in = 0; R6in = 0; R7in = 0; IncPC = 0; Read = 0; MUL = 0;
   endtask

   // Advance one rising edge and leave inputs idle, 1 time unit past the edge.
   task automatic tick();
      @(posedge Clock);
      #1;
      idle();
   endtask

   // dst: 0=R6, 1=R7, 2=R1, 3=PC
   task automatic load_reg(input int dst, input logic [31:0] val);
      Mdatain = val; Read = 1; MDRin = 1;
      tick();
      MDRout = 1;
      case (dst)
         0: R6in = 1;
         1: R7in = 1;
         2: R1in = 1;
         default: PCin = 1;
      endcase
      tick();
   endtask

   task automatic run_op(input op_t op);
      R6out = 1; Yin = 1;
      tick();
      R7out = 1; Zin = 1;
      if (op == OP_MUL) MUL = 1;
      if (op == OP_INC) IncPC = 1;
      tick();
      Zlowout = 1; LOin = 1;
      tick();
      Zhighout = 1; HIin = 1;
      tick();
   endtask

   initial begin
      total = 0;
      passed = 0;
      idle();
      Mdatain = '0;
      Resetn = 1'b0;

      vecs[0]  = '{OP_MUL, 32'h00000012, 32'h00000014, 32'h00000000, 32'h00000168};
      vecs[1]  = '{OP_MUL, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
      vecs[2]  = '{OP_MUL, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vecs[3]  = '{OP_MUL, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
      vecs[4]  = '{OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
      vecs[5]  = '{OP_MUL, 32'h80000000, 32'h7FFFFFFF, 32'hC0000000, 32'h80000000};
      vecs[6]  = '{OP_MUL, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000};
      vecs[7]  = '{OP_MUL, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
      vecs[8]  = '{OP_ADD, 32'h00000007, 32'h00000007, 32'h00000000, 32'h0000000E};
      vecs[9]  = '{OP_ADD, 32'hFFFFFFFF, 32'h00000002, 32'h00000000, 32'h00000001};
      vecs[10] = '{OP_INC, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};
      vecs[11] = '{OP_INC, 32'h00000000, 32'h00000041, 32'h00000000, 32'h00000042};

      tick();
      tick();
      Resetn = 1'b1;

      // Reset clears registers loaded with arbitrary values.
      load_reg(0, 32'hDEADBEEF);
      load_reg(1, 32'h00000003);
      load_reg(3, 32'h55AA55AA);
      run_op(OP_MUL);
      Resetn = 1'b0;
      tick();
      Resetn = 1'b1;
      check("rst_pc", PC_q, 32'h0);
      check("rst_ir", IR_q, 32'h0);
      check("rst_mar", MAR_q, 32'h0);
      check("rst_hi", HI_q, 32'h0);
      check("rst_lo", LO_q, 32'h0);
      check("rst_bus_idle", BusMuxOut, 32'h0);
      MDRout = 1; #1; check("rst_mdr", BusMuxOut, 32'h0); idle();
      R6out = 1;  #1; check("rst_r6", BusMuxOut, 32'h0); idle();
      Zhighout = 1; #1; check("rst_zhi", BusMuxOut, 32'h0); idle();

      // Register loads through MDR.
      load_reg(0, 32'h12);
      R6out = 1; #1; check("r6_load", BusMuxOut, 32'h12); idle();
      load_reg(1, 32'h14);
      R7out = 1; #1; check("r7_load", BusMuxOut, 32'h14); idle();
      load_reg(2, 32'h18);
      Mdatain = 32'hCAFEF00D; Read = 1;
      tick();
      MDRout = 1; #1; check("read_no_mdrin", BusMuxOut, 32'h18); idle();

      // Instruction fetch from PC=0.
      Resetn = 1'b0; tick(); Resetn = 1'b1;
      Mdatain = 32'h28918000;
      PCout = 1; MARin = 1; IncPC = 1; Zin = 1; tick();
      Zlowout = 1; PCin = 1; Read = 1; MDRin = 1; tick();
      MDRout = 1; IRin = 1; tick();
      check("fetch_mar", MAR_q, 32'h0);
      check("fetch_pc", PC_q, 32'h1);
      check("fetch_ir", IR_q, 32'h28918000);

      // Fetch with PC at all-ones wraps to zero.
      load_reg(3, 32'hFFFFFFFF);
      Mdatain = 32'h0BADC0DE;
      PCout = 1; MARin = 1; IncPC = 1; Zin = 1; tick();
      Zlowout = 1; PCin = 1; Read = 1; MDRin = 1; tick();
      MDRout = 1; IRin = 1; tick();
      check("wrap_mar", MAR_q, 32'hFFFFFFFF);
      check("wrap_pc", PC_q, 32'h0);
      check("wrap_ir", IR_q, 32'h0BADC0DE);

      // ALU vector table.
      for (int i = 0; i < 12; i++) begin
         load_reg(0, vecs[i].a);
         load_reg(1, vecs[i].b);
         run_op(vecs[i].op);
         check($sformatf("vec%0d_lo", i), LO_q, vecs[i].exp_lo);
         check($sformatf("vec%0d_hi", i), HI_q, vecs[i].exp_hi);
      end

      // Bus priority with non-one-hot selects; Z low holds 0xE from an add.
      load_reg(0, 32'h7);
      load_reg(1, 32'h7);
      load_reg(3, 32'h00000ABC);
      R6out = 1; Yin = 1; tick();
      R7out = 1; Zin = 1; tick();
      Zlowout = 1; PCout = 1; #1; check("prio_zlo_pc", BusMuxOut, 32'h0000000E); idle();
      Zhighout = 1; Zlowout = 1; #1; check("prio_zhi_zlo", BusMuxOut, 32'h0); idle();
      R7out = 1; R6out = 1; MDRout = 1; #1; check("prio_r7", BusMuxOut, 32'h7); idle();
      MDRout = 1; PCout = 1; #1; check("prio_mdr_pc", BusMuxOut, 32'h00000ABC); idle();
      PCout = 1; #1; check("pc_only", BusMuxOut, 32'h00000ABC); idle();

      // Same-cycle read/write: bus shows old value, register then holds it.
      load_reg(1, 32'h99);
      R7out = 1; R7in = 1; #1; check("rw_old_val", BusMuxOut, 32'h99);
      tick();
      R7out = 1; #1; check("rw_hold", BusMuxOut, 32'h99); idle();

      // Reset mid-multiply discards the in-flight product.
      load_reg(0, 32'h100);
      load_reg(1, 32'h200);
      R6out = 1; Yin = 1; tick();
      R7out = 1; MUL = 1; Zin = 1; tick();
      Resetn = 1'b0; tick(); Resetn = 1'b1;
      Zlowout = 1; LOin = 1; tick();
      Zhighout = 1; HIin = 1; tick();
      check("midrst_lo", LO_q, 32'h0);
      check("midrst_hi", HI_q, 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
